// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer: turns one read/write request into the START/WR/RESTART/RD/STOP
// command stream for a byte-level I2C master and returns a single response per request.
module i2c_reg_sequencer #(
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [3:0] CMD,
  output logic [7:0] tx_data,
  input  logic       m_ready,
  input  logic       m_tx_done,
  input  logic       m_rx_done,
  input  logic [7:0] m_rx_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TOUT_ONE  = CW'(1);

  localparam logic [3:0] CMD_IDLE    = 4'd0;
  localparam logic [3:0] CMD_START   = 4'd1;
  localparam logic [3:0] CMD_STOP    = 4'd2;
  localparam logic [3:0] CMD_RESTART = 4'd3;
  localparam logic [3:0] CMD_RD      = 4'd4;
  localparam logic [3:0] CMD_WR      = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_ACCEPT = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_RESP        = 3'd4
  } state_t;

  state_t        state_r;
  logic          rw_r;
  logic [6:0]    dev_r;
  logic [7:0]    reg_r;
  logic [7:0]    wdata_r;
  logic [2:0]    step_r;
  logic [CW-1:0] tout_cnt_r;
  logic [7:0]    rdata_hold_r;
  logic          rx_done_prev_r;
  logic          tx_done_prev_r;
  logic [7:0]    tx_edge_cnt_r;

  logic [3:0]    step_cmd_s;
  logic [7:0]    step_data_s;
  logic          step_last_s;
  logic          rx_rise_s;
  logic [7:0]    rx_byte_s;

  // Decode the current step of the latched request into a master command and its data byte.
  always_comb begin
    step_cmd_s  = CMD_IDLE;
    step_data_s = 8'h00;
    step_last_s = 1'b0;
    if (rw_r) begin
      case (step_r)
        3'd0: step_cmd_s = CMD_START;
        3'd1: begin step_cmd_s = CMD_WR; step_data_s = {dev_r, 1'b0}; end
        3'd2: begin step_cmd_s = CMD_WR; step_data_s = reg_r; end
        3'd3: step_cmd_s = CMD_RESTART;
        3'd4: begin step_cmd_s = CMD_WR; step_data_s = {dev_r, 1'b1}; end
        3'd5: step_cmd_s = CMD_RD;
        3'd6: begin step_cmd_s = CMD_STOP; step_last_s = 1'b1; end
        default: begin step_cmd_s = CMD_STOP; step_last_s = 1'b1; end
      endcase
    end else begin
      case (step_r)
        3'd0: step_cmd_s = CMD_START;
        3'd1: begin step_cmd_s = CMD_WR; step_data_s = {dev_r, 1'b0}; end
        3'd2: begin step_cmd_s = CMD_WR; step_data_s = reg_r; end
        3'd3: begin step_cmd_s = CMD_WR; step_data_s = wdata_r; end
        3'd4: begin step_cmd_s = CMD_STOP; step_last_s = 1'b1; end
        default: begin step_cmd_s = CMD_STOP; step_last_s = 1'b1; end
      endcase
    end
  end

  // Read byte capture: a same-cycle rx_done edge wins over the held value.
  always_comb begin
    rx_rise_s = m_rx_done & ~rx_done_prev_r;
    if ((state_r == S_WAIT_DONE) && rx_rise_s) begin
      rx_byte_s = m_rx_data;
    end else begin
      rx_byte_s = rdata_hold_r;
    end
  end

  // Previous-value registers for master done levels; tx_done edges are counted for debug only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_prev_r <= 1'b0;
      tx_done_prev_r <= 1'b0;
      tx_edge_cnt_r  <= 8'h00;
    end else begin
      rx_done_prev_r <= m_rx_done;
      tx_done_prev_r <= m_tx_done;
      if (m_tx_done && !tx_done_prev_r) begin
        tx_edge_cnt_r <= tx_edge_cnt_r + 8'h01;
      end
    end
  end

  // Sequencer FSM with registered handshake and command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 8'h00;
      CMD          <= CMD_IDLE;
      tx_data      <= 8'h00;
      step_r       <= 3'd0;
      tout_cnt_r   <= '0;
      rw_r         <= 1'b0;
      dev_r        <= 7'h00;
      reg_r        <= 8'h00;
      wdata_r      <= 8'h00;
      rdata_hold_r <= 8'h00;
    end else begin
      CMD       <= CMD_IDLE;
      tx_data   <= 8'h00;
      rsp_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          tout_cnt_r <= '0;
          if (req_valid && req_ready) begin
            rw_r         <= req_rw;
            dev_r        <= req_dev_addr;
            reg_r        <= req_reg_addr;
            wdata_r      <= req_wdata;
            step_r       <= 3'd0;
            rdata_hold_r <= 8'h00;
            busy         <= 1'b1;
            req_ready    <= 1'b0;
            state_r      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            CMD        <= step_cmd_s;
            tx_data    <= step_data_s;
            tout_cnt_r <= '0;
            state_r    <= S_WAIT_ACCEPT;
          end
        end
        S_WAIT_ACCEPT: begin
          if (!m_ready) begin
            tout_cnt_r <= '0;
            state_r    <= S_WAIT_DONE;
          end else if (tout_cnt_r == TOUT_LAST) begin
            // The master has already released the bus after a NACK; abort without STOP.
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= 8'h00;
            busy       <= 1'b0;
            tout_cnt_r <= '0;
            state_r    <= S_RESP;
          end else begin
            tout_cnt_r <= tout_cnt_r + TOUT_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (rx_rise_s) begin
            rdata_hold_r <= m_rx_data;
          end
          if (m_ready) begin
            if (step_last_s) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rw_r ? rx_byte_s : 8'h00;
              busy      <= 1'b0;
              state_r   <= S_RESP;
            end else begin
              step_r  <= step_r + 3'd1;
              state_r <= S_ISSUE;
            end
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          step_r    <= 3'd0;
          state_r   <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          step_r    <= 3'd0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural byte-level master with NACK and long rx_done options.
module tb_i2c_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev_addr = 7'h00;
  logic [7:0] req_reg_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [3:0] CMD;
  logic [7:0] tx_data;
  logic       m_ready = 1'b1;
  logic       m_tx_done = 1'b0;
  logic       m_rx_done = 1'b0;
  logic [7:0] m_rx_data = 8'h00;

  i2c_reg_sequencer #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .CMD(CMD), .tx_data(tx_data),
    .m_ready(m_ready), .m_tx_done(m_tx_done), .m_rx_done(m_rx_done), .m_rx_data(m_rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [11:0] seq_t [7];
  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] slave;
    logic       nack;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_n;
    seq_t       cmds;
  } vec_t;

  vec_t vecs [5];
  int n_checks = 0;
  int n_fail = 0;

  // Master model state, advanced on the falling edge.
  logic [11:0] cmd_log [$];
  int          pulse_err = 0;
  logic        cmd_prev = 1'b0;
  logic        bus_active = 1'b0;
  logic [3:0]  cur_cmd = 4'd0;
  int          mcnt = 0;
  int          rx_hold = 0;
  int          tx_hold = 0;
  int          rx_len = 3;
  int          wr_count = 0;
  logic [7:0]  slave_byte = 8'h00;
  logic        nack_first = 1'b0;
  int          stop_done_cyc = -100;

  always @(negedge clk) begin
    if (reset) begin
      m_ready = 1'b1; m_tx_done = 1'b0; m_rx_done = 1'b0;
      bus_active = 1'b0; mcnt = 0; rx_hold = 0; tx_hold = 0; wr_count = 0; cmd_prev = 1'b0;
    end else begin
      if (CMD != 4'd0) begin
        cmd_log.push_back({CMD, tx_data});
        if (cmd_prev) pulse_err++;
      end
      cmd_prev = (CMD != 4'd0);
      if (rx_hold > 0) begin
        rx_hold--;
        if (rx_hold == rx_len - 2) m_rx_data = 8'hFF;
        if (rx_hold == 0) m_rx_done = 1'b0;
      end
      if (tx_hold > 0) begin
        tx_hold--;
        if (tx_hold == 0) m_tx_done = 1'b0;
      end
      if (m_ready) begin
        // Without an open bus transaction only START is taken.
        if (CMD != 4'd0 && (bus_active || CMD == 4'd1)) begin
          m_ready = 1'b0; cur_cmd = CMD; mcnt = 3;
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          case (cur_cmd)
            4'd1: begin bus_active = 1'b1; wr_count = 0; end
            4'd2: begin bus_active = 1'b0; stop_done_cyc = cyc; end
            4'd4: begin m_rx_done = 1'b1; m_rx_data = slave_byte; rx_hold = rx_len; end
            4'd5: begin
              m_tx_done = 1'b1; tx_hold = 2;
              if (nack_first && wr_count == 0) bus_active = 1'b0;
              wr_count++;
            end
            default: ;
          endcase
          m_ready = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int exp_n, input seq_t exp);
    chk($sformatf("%s_ncmd", tag), cmd_log.size(), exp_n);
    for (int i = 0; i < exp_n && i < cmd_log.size(); i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), {28'd0, cmd_log[i][11:8]}, {28'd0, exp[i][11:8]});
      if (exp[i][11:8] == 4'd5)
        chk($sformatf("%s_data%0d", tag, i), {24'd0, cmd_log[i][7:0]}, {24'd0, exp[i][7:0]});
    end
  endtask

  // Called right after the acceptance edge; returns at the negedge showing rsp_valid.
  task automatic wait_rsp(output int n_rsp, output logic err, output logic [7:0] rdata,
                          output int first_lat, output int rsp_cyc);
    int k;
    k = 1; n_rsp = 0; first_lat = -1; err = 1'b0; rdata = 8'h00; rsp_cyc = 0;
    while (k < 3000 && n_rsp == 0) begin
      if (first_lat < 0 && CMD != 4'd0) first_lat = k;
      if (rsp_valid) begin
        n_rsp = 1; err = rsp_err; rdata = rsp_rdata; rsp_cyc = cyc;
      end else begin
        @(negedge clk); k++;
      end
    end
  endtask

  task automatic run_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, output int n_rsp, output logic err,
                         output logic [7:0] rdata, output int first_lat, output int rsp_cyc);
    req_rw = rw; req_dev_addr = dev; req_reg_addr = rg; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(n_rsp, err, rdata, first_lat, rsp_cyc);
  endtask

  int         n_rsp, first_lat, rsp_cyc, extra;
  logic       err;
  logic [7:0] rdata;

  initial begin
    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 5,
                '{12'h100, 12'h5A0, 12'h510, 12'h5A5, 12'h200, 12'h000, 12'h000}};
    vecs[1] = '{1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C, 7,
                '{12'h100, 12'h5A0, 12'h510, 12'h300, 12'h5A1, 12'h400, 12'h200}};
    vecs[2] = '{1'b0, 7'h2A, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 5,
                '{12'h100, 12'h554, 12'h5FF, 12'h500, 12'h200, 12'h000, 12'h000}};
    vecs[3] = '{1'b1, 7'h7F, 8'h00, 8'h99, 8'hC3, 1'b0, 1'b0, 8'hC3, 7,
                '{12'h100, 12'h5FE, 12'h500, 12'h300, 12'h5FF, 12'h400, 12'h200}};
    vecs[4] = '{1'b0, 7'h50, 8'h10, 8'h11, 8'h00, 1'b1, 1'b1, 8'h00, 3,
                '{12'h100, 12'h5A0, 12'h510, 12'h000, 12'h000, 12'h000, 12'h000}};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd", CMD, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      slave_byte = vecs[i].slave; nack_first = vecs[i].nack;
      stop_done_cyc = -100; cmd_log.delete();
      run_req(vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd, n_rsp, err, rdata, first_lat, rsp_cyc);
      chk($sformatf("v%0d_rsp_seen", i), n_rsp, 1);
      chk($sformatf("v%0d_rsp_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_rsp_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_busy_at_rsp", i), busy, 0);
      chk($sformatf("v%0d_first_cmd_lat", i), (first_lat >= 1 && first_lat <= 2), 1);
      if (!vecs[i].exp_err)
        chk($sformatf("v%0d_stop_to_rsp", i), rsp_cyc - stop_done_cyc, 1);
      chk_log($sformatf("v%0d", i), vecs[i].exp_n, vecs[i].cmds);
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), req_ready, 1);
      chk($sformatf("v%0d_rsp_one_cycle", i), rsp_valid, 0);
    end
    nack_first = 1'b0;

    // req_valid held through a busy write while the fields change.
    cmd_log.delete();
    req_rw = 1'b0; req_dev_addr = 7'h33; req_reg_addr = 8'h44; req_wdata = 8'h55; req_valid = 1'b1;
    @(negedge clk);
    chk("hold_busy_a", busy, 1);
    req_dev_addr = 7'h12; req_reg_addr = 8'h34; req_wdata = 8'h56;
    wait_rsp(n_rsp, err, rdata, first_lat, rsp_cyc);
    chk("hold_rsp_a", n_rsp, 1);
    chk_log("hold_a", 5, '{12'h100, 12'h566, 12'h544, 12'h555, 12'h200, 12'h000, 12'h000});
    cmd_log.delete();
    @(negedge clk);
    chk("hold_ready_after_a", req_ready, 1);
    chk("hold_rsp_single", rsp_valid, 0);
    @(negedge clk);
    chk("hold_busy_b", busy, 1);
    req_valid = 1'b0;
    wait_rsp(n_rsp, err, rdata, first_lat, rsp_cyc);
    chk("hold_rsp_b", n_rsp, 1);
    chk("hold_err_b", err, 0);
    chk_log("hold_b", 5, '{12'h100, 12'h524, 12'h534, 12'h556, 12'h200, 12'h000, 12'h000});
    @(negedge clk);

    // Reset while the register-address byte is on the bus.
    cmd_log.delete();
    req_rw = 1'b0; req_dev_addr = 7'h50; req_reg_addr = 8'h10; req_wdata = 8'h77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 200 && !(CMD == 4'd5 && tx_data == 8'h10); k++) @(negedge clk);
    chk("rst_mid_reached_wr_reg", (CMD == 4'd5 && tx_data == 8'h10), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd", CMD, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    chk("rst_mid_no_rsp", extra, 0);
    cmd_log.delete(); stop_done_cyc = -100;
    run_req(1'b0, 7'h50, 8'h10, 8'h77, n_rsp, err, rdata, first_lat, rsp_cyc);
    chk("rst_after_rsp", n_rsp, 1);
    chk("rst_after_err", err, 0);
    chk_log("rst_after", 5, '{12'h100, 12'h5A0, 12'h510, 12'h577, 12'h200, 12'h000, 12'h000});
    @(negedge clk);

    // rx_done held for 250 cycles; rx_data changes shortly after the rising edge.
    rx_len = 250; slave_byte = 8'h3C; cmd_log.delete();
    run_req(1'b1, 7'h50, 8'h10, 8'h00, n_rsp, err, rdata, first_lat, rsp_cyc);
    chk("rxlong_rsp", n_rsp, 1);
    chk("rxlong_rdata", rdata, 8'h3C);
    extra = 0;
    for (int k = 0; k < 400 && m_rx_done; k++) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    chk("rxlong_pulse_ended", m_rx_done, 0);
    chk("rxlong_no_extra_rsp", extra, 0);
    chk("rxlong_rdata_held", rsp_rdata, 8'h3C);
    rx_len = 3;

    chk("single_cycle_cmd", pulse_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Transaction sequencer that sits directly upstream of the I2C byte-level master (CMD/tx_data/ready/tx_done/rx_done interface).
- Accepts one register-access request (7-bit device address, 8-bit register address, write data or read) and issues the full command sequence to the master.
- Returns one response per request with read data and an error flag.
- Typically driven by an AXI-lite register bank or a small init ROM.

Parameters:
- TIMEOUT, 4095: cycles a command may remain unaccepted (master ready stays high) before the transaction aborts with error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request strobe; accepted when req_valid && req_ready
- req_ready  out  1  high only in IDLE
- req_rw  in  1  0=write, 1=read
- req_dev_addr  in  7  slave address
- req_reg_addr  in  8  register address
- req_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  valid with rsp_valid; 1 = timeout/NACK abort
- rsp_rdata  out  8  read byte; 0x00 for writes; held until next response
- busy  out  1  high from acceptance to rsp_valid
- CMD  out  4  to master: 0 IDLE, 1 START, 2 STOP, 3 RESTART, 4 RD, 5 WR
- tx_data  out  8  to master, byte for WR
- m_ready  in  1  master ready
- m_tx_done  in  1  master tx_done (level, many cycles)
- m_rx_done  in  1  master rx_done (level, many cycles)
- m_rx_data  in  8  master rx_data

Behaviour:
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0x00, CMD=0, tx_data=0x00, step=0, timeout counter=0.
- On acceptance, latch rw, dev, reg, wdata into internal registers. Inputs are ignored while busy.
- Step list, write: START; WR {dev,0}; WR reg; WR wdata; STOP (5 steps).
- Step list, read: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; RD; STOP (7 steps).
- FSM: IDLE -> ISSUE -> WAIT_ACCEPT -> WAIT_DONE -> (next step: ISSUE | last step: RESP) -> IDLE.
- IDLE: CMD=0, req_ready=1. On req_valid, go to ISSUE next cycle.
- ISSUE: waits for m_ready=1. In the cycle m_ready=1, drives CMD and tx_data for exactly one cycle (registered outputs), then goes to WAIT_ACCEPT. CMD=0 in every other state.
- WAIT_ACCEPT:
  - m_ready=0 -> WAIT_DONE and clear the timeout counter.
  - Otherwise increment the counter.
  - Counter == TIMEOUT-1 -> RESP with err=1. No further commands are issued; the master has already stopped itself on NACK.
- WAIT_DONE:
  - Waits for m_ready=1, with no timeout.
  - On a rising edge of m_rx_done (registered previous value), latch m_rx_data into the read holding register.
  - m_tx_done is monitored only for debug/edge counting; advancing is driven by m_ready.
- RESP: rsp_valid=1 for one cycle with rsp_err and rsp_rdata (read value, or 0x00 for writes/errors); busy drops in the same cycle; then IDLE.
- Latency: request acceptance to first CMD is at most 2 cycles when m_ready=1. Last STOP completion (m_ready rise) to rsp_valid is 1 cycle.
- Back-to-back: a new request is accepted the cycle after rsp_valid (req_ready high in IDLE).
- Simultaneous rx_done rising edge and m_ready rising edge: data is latched, then the FSM advances.
- Reset mid-transaction: all state returns to reset values on the next clk edge. CMD=0 immediately. No response is generated for the aborted request.
- Timeout counter width: $clog2(TIMEOUT+1).

Test Plan:
- Write dev 0x50 reg 0x10 data 0xA5 with master model -> CMD sequence 1; 5/0xA0; 5/0x10; 5/0xA5; 2, each a single-cycle pulse; then rsp_valid=1, rsp_err=0, rsp_rdata=0x00.
- Read dev 0x50 reg 0x10, slave model returns 0x3C -> CMD sequence 1; 5/0xA0; 5/0x10; 3; 5/0xA1; 4; 2; then rsp_rdata=0x3C, rsp_err=0.
- Slave NACKs the address byte (master self-STOPs to IDLE) -> the next WR is ignored; after TIMEOUT=64 cycles (override), rsp_valid with rsp_err=1; no STOP issued; req_ready=1 the following cycle.
- req_valid held high with new fields during a busy write -> fields ignored; exactly one rsp_valid; the second request is accepted in the cycle after rsp_valid and runs with its own fields.
- Reset asserted during the WR reg step -> next cycle CMD=0, busy=0, req_ready=1, no rsp_valid; a subsequent write completes normally.
- m_rx_done held high for 250 cycles -> rsp_rdata latched once, on the rising edge; m_rx_data changing later during the pulse does not alter rsp_rdata.
